// File: rtl/d_mem_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package d_mem_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned PORT_CORE  = 0;
  localparam int unsigned PORT_AUX   = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Misaligned or beyond the last implemented word.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] addr, input int unsigned mem_words);
    return (addr[WORD_SHIFT-1:0] != '0) || ((addr >> WORD_SHIFT) >= ADDR_W'(mem_words));
  endfunction

endpackage

// File: rtl/d_mem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: valid/ready request, one-cycle response pulse.
interface d_mem_arbiter_if;
  import d_mem_pkg::*;

  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output valid, we, addr, wdata, input  ready, rvalid, rdata, err);
  modport slave  (input  valid, we, addr, wdata, output ready, rvalid, rdata, err);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    else              gnt = req;
  end

endmodule

// File: rtl/d_mem_arbiter.sv
// Shares one single-port data memory between the core (port 0) and the loader/DMA (port 1),
// one non-pipelined transaction at a time with optional wait states.
module d_mem_arbiter
  import d_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MEM_WORDS   = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  d_mem_arbiter_if.slave    p0,
  d_mem_arbiter_if.slave    p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              r_state;
  logic                r_last;
  logic                r_owner;
  logic                r_we;
  logic [WAIT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [1:0]          r_rvalid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_err;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_idle;
  logic                w_hs;
  logic                w_owner;
  logic                w_bad;
  req_t                w_sel;

  assign w_req = {p1.valid, p0.valid};

  rr_arb2 u_arb (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  // Acceptance is only possible while idle; ready is therefore combinational.
  assign w_idle   = (r_state == S_IDLE);
  assign w_hs     = w_idle & (|w_gnt);
  assign w_owner  = w_gnt[PORT_AUX];
  assign w_sel    = w_owner ? {p1.we, p1.addr, p1.wdata} : {p0.we, p0.addr, p0.wdata};
  assign w_bad    = addr_bad(w_sel.addr, MEM_WORDS);

  assign p0.ready = w_idle & w_gnt[PORT_CORE];
  assign p1.ready = w_idle & w_gnt[PORT_AUX];

  assign p0.rvalid = r_rvalid[PORT_CORE];
  assign p1.rvalid = r_rvalid[PORT_AUX];
  assign p0.rdata  = r_resp_rdata;
  assign p1.rdata  = r_resp_rdata;
  assign p0.err    = r_resp_err;
  assign p1.err    = r_resp_err;

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_rvalid     <= 2'b00;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_last  <= w_owner;
            r_owner <= w_owner;
            r_we    <= w_sel.we;
            if (w_bad) begin
              // Rejected requests skip the memory entirely.
              r_state      <= S_RESP;
              r_rvalid     <= w_owner ? 2'b10 : 2'b01;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end else begin
              r_state     <= S_ACCESS;
              r_cnt       <= WAIT_W'(WAIT_STATES);
              r_mem_addr  <= w_sel.addr;
              r_mem_wdata <= w_sel.wdata;
              r_mem_read  <= ~w_sel.we;
              r_mem_write <= w_sel.we;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            // Last strobe cycle: sample read data and drop the strobes.
            r_state      <= S_RESP;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rvalid     <= r_owner ? 2'b10 : 2'b01;
            r_resp_rdata <= r_we ? '0 : mem_rdata;
            r_resp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_rvalid     <= 2'b00;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: two instances (0 and 2 wait states) against a timestamp-based model.
module tb_d_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index [k][p]: k = instance (0: no wait states, 1: two), p = port.
  logic        v     [2][2];
  logic        we_i  [2][2];
  logic [31:0] ad    [2][2];
  logic [31:0] wd    [2][2];
  logic        rdy   [2][2];
  logic        rv    [2][2];
  logic        er_o  [2][2];
  logic [31:0] rd_o  [2][2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata[2];
  logic [31:0] mrdata[2];
  logic        mread [2];
  logic        mwrite[2];

  d_mem_arbiter_if if00 ();
  d_mem_arbiter_if if01 ();
  d_mem_arbiter_if if10 ();
  d_mem_arbiter_if if11 ();

  assign if00.valid = v[0][0]; assign if00.we = we_i[0][0]; assign if00.addr = ad[0][0]; assign if00.wdata = wd[0][0];
  assign if01.valid = v[0][1]; assign if01.we = we_i[0][1]; assign if01.addr = ad[0][1]; assign if01.wdata = wd[0][1];
  assign if10.valid = v[1][0]; assign if10.we = we_i[1][0]; assign if10.addr = ad[1][0]; assign if10.wdata = wd[1][0];
  assign if11.valid = v[1][1]; assign if11.we = we_i[1][1]; assign if11.addr = ad[1][1]; assign if11.wdata = wd[1][1];
  assign rdy[0][0] = if00.ready; assign rv[0][0] = if00.rvalid; assign rd_o[0][0] = if00.rdata; assign er_o[0][0] = if00.err;
  assign rdy[0][1] = if01.ready; assign rv[0][1] = if01.rvalid; assign rd_o[0][1] = if01.rdata; assign er_o[0][1] = if01.err;
  assign rdy[1][0] = if10.ready; assign rv[1][0] = if10.rvalid; assign rd_o[1][0] = if10.rdata; assign er_o[1][0] = if10.err;
  assign rdy[1][1] = if11.ready; assign rv[1][1] = if11.rvalid; assign rd_o[1][1] = if11.rdata; assign er_o[1][1] = if11.err;

  d_mem_arbiter #(.WAIT_STATES(0), .MEM_WORDS(1024)) dut0 (
    .clk(clk), .reset_n(reset_n), .p0(if00), .p1(if01),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_read(mread[0]), .mem_write(mwrite[0]),
    .mem_rdata(mrdata[0]));

  d_mem_arbiter #(.WAIT_STATES(2), .MEM_WORDS(1024)) dut1 (
    .clk(clk), .reset_n(reset_n), .p0(if10), .p1(if11),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_read(mread[1]), .mem_write(mwrite[1]),
    .mem_rdata(mrdata[1]));

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 ^ 32'(i));
  endfunction

  // Memories: asynchronous read, synchronous write.
  logic [31:0] tbmem [2][1024];
  bit          mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 1024; i++) tbmem[k][i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (mwrite[k]) tbmem[k][maddr[k][11:2]] <= mwdata[k];
    end
  end
  assign mrdata[0] = tbmem[0][maddr[0][11:2]];
  assign mrdata[1] = tbmem[1][maddr[1][11:2]];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Activity counters, read by the directed tests between transactions.
  int wcnt[2], rcnt[2], rdycnt[2][2], rvcnt[2][2];
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mwrite[k]) wcnt[k]++;
      if (mread[k])  rcnt[k]++;
      for (int p = 0; p < 2; p++) begin
        if (rdy[k][p]) rdycnt[k][p]++;
        if (rv[k][p])  rvcnt[k][p]++;
      end
    end
  end

  // Model: each accepted transaction is a set of cycle timestamps (strobe window, response cycle).
  logic [31:0] ref_mem [2][1024];
  bit          ref_ready;
  int          m_resp[2], m_as[2], m_ae[2];
  logic        m_last[2], m_owner[2], m_we[2], m_err[2];
  logic [31:0] m_addr[2], m_wd[2], m_rd[2];

  always @(negedge clk) begin
    int  g, w;
    bit  idle, strobe, exp_rv;
    if (!ref_ready) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
      ref_ready = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? 0 : 2;
      if (!reset_n) begin
        m_resp[k] = -1; m_as[k] = 1; m_ae[k] = 0; m_last[k] = 1'b1;
        chk("rst_mem_read",  k, mread[k],  0);
        chk("rst_mem_write", k, mwrite[k], 0);
        chk("rst_mem_addr",  k, maddr[k],  0);
        chk("rst_rvalid0",   k, rv[k][0],  0);
        chk("rst_rvalid1",   k, rv[k][1],  0);
      end else begin
        idle   = (cyc > m_resp[k]);
        strobe = (cyc >= m_as[k]) && (cyc <= m_ae[k]);
        chk("mem_read",  k, mread[k],  strobe && !m_we[k]);
        chk("mem_write", k, mwrite[k], strobe && m_we[k]);
        if (strobe) begin
          chk("mem_addr", k, maddr[k], m_addr[k]);
          if (m_we[k]) chk("mem_wdata", k, mwdata[k], m_wd[k]);
        end
        for (int p = 0; p < 2; p++) begin
          exp_rv = (cyc == m_resp[k]) && (int'(m_owner[k]) == p);
          chk("rvalid", k, rv[k][p], exp_rv);
          if (exp_rv) begin
            chk("rdata", k, rd_o[k][p], m_rd[k]);
            chk("err",   k, er_o[k][p], m_err[k]);
          end
        end
        g = -1;
        if (v[k][0] && v[k][1]) g = m_last[k] ? 0 : 1;
        else if (v[k][0])       g = 0;
        else if (v[k][1])       g = 1;
        chk("ready0", k, rdy[k][0], idle && g == 0);
        chk("ready1", k, rdy[k][1], idle && g == 1);
        if (idle && g >= 0) begin
          m_last[k]  = g[0];
          m_owner[k] = g[0];
          m_we[k]    = we_i[k][g];
          m_addr[k]  = ad[k][g];
          m_wd[k]    = wd[k][g];
          m_err[k]   = (ad[k][g] % 4 != 0) || (ad[k][g] >= 32'(4 * 1024));
          m_rd[k]    = 32'h0;
          if (m_err[k]) begin
            m_resp[k] = cyc + 1; m_as[k] = 1; m_ae[k] = 0;
          end else begin
            m_as[k] = cyc + 1; m_ae[k] = cyc + 1 + w; m_resp[k] = cyc + w + 2;
            if (m_we[k]) ref_mem[k][ad[k][g] / 4] = wd[k][g];
            else         m_rd[k] = ref_mem[k][ad[k][g] / 4];
          end
        end
      end
    end
  end

  task automatic do_req(input int k, input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int t_hs, output int t_rv, output logic [31:0] rdat, output logic rerr);
    @(posedge clk); #1;
    v[k][p] = 1'b1; we_i[k][p] = w; ad[k][p] = a; wd[k][p] = d;
    t_hs = -1; t_rv = -1; rdat = 'x; rerr = 1'bx;
    for (int i = 0; i < 40 && t_hs < 0; i++) begin
      @(negedge clk);
      if (rdy[k][p]) t_hs = cyc;
    end
    @(posedge clk); #1 v[k][p] = 1'b0;
    for (int i = 0; i < 40 && t_rv < 0; i++) begin
      @(negedge clk);
      if (rv[k][p]) begin t_rv = cyc; rdat = rd_o[k][p]; rerr = er_o[k][p]; end
    end
    chk("handshake_seen", k, 32'(t_hs >= 0), 32'd1);
    chk("rvalid_seen",    k, 32'(t_rv >= 0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int          ths, trv, ths2, trv2, snap, snap2, n, first;
    int          order[4];
    int          exp_order[4];
    logic [31:0] rdat, rdat2;
    logic        rerr, rerr2;
    exp_order = '{0, 1, 0, 1};
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin v[k][p] = 0; we_i[k][p] = 0; ad[k][p] = 0; wd[k][p] = 0; end

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", k, rd_o[k][0], 0);
      chk("reset_err",   k, er_o[k][1], 0);
      chk("reset_wdata", k, mwdata[k], 0);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: p0 read of word 4, no wait states
    snap = rcnt[0];
    do_req(0, 0, 1'b0, 32'h10, 32'h0, ths, trv, rdat, rerr);
    chk("t1_latency", 0, trv - ths, 2);
    chk("t1_rdata",   0, rdat, 32'hDEADBEEF);
    chk("t1_err",     0, rerr, 0);
    chk("t1_read_cycles", 0, rcnt[0] - snap, 1);

    // 2: p1 write then read back, two wait states
    snap = wcnt[1];
    do_req(1, 1, 1'b1, 32'h20, 32'h12345678, ths, trv, rdat, rerr);
    chk("t2_write_cycles", 1, wcnt[1] - snap, 3);
    chk("t2_wr_latency",   1, trv - ths, 4);
    chk("t2_wr_rdata",     1, rdat, 0);
    do_req(1, 1, 1'b0, 32'h20, 32'h0, ths, trv, rdat, rerr);
    chk("t2_rd_latency",   1, trv - ths, 4);
    chk("t2_rd_rdata",     1, rdat, 32'h12345678);
    chk("t2_rd_err",       1, rerr, 0);

    // 4: misaligned and out-of-range requests never touch memory
    snap = wcnt[0] + rcnt[0];
    do_req(0, 0, 1'b0, 32'h13, 32'h0, ths, trv, rdat, rerr);
    chk("t4_mis_err",     0, rerr, 1);
    chk("t4_mis_rdata",   0, rdat, 0);
    chk("t4_mis_latency", 0, trv - ths, 1);
    do_req(0, 1, 1'b0, 32'h1000, 32'h0, ths, trv, rdat, rerr);
    chk("t4_oor_err",     0, rerr, 1);
    chk("t4_oor_rdata",   0, rdat, 0);
    chk("t4_no_strobes",  0, wcnt[0] + rcnt[0] - snap, 0);

    // 6: brief p1 request while busy is never granted
    snap = rdycnt[1][1]; snap2 = rvcnt[1][1];
    fork
      do_req(1, 0, 1'b0, 32'h40, 32'h0, ths2, trv2, rdat2, rerr2);
      begin
        repeat (2) @(posedge clk);
        #1 v[1][1] = 1'b1; we_i[1][1] = 1'b0; ad[1][1] = 32'h44;
        @(posedge clk);
        #1 v[1][1] = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("t6_p0_rdata", 1, rdat2, init_word(16));
    chk("t6_p1_ready", 1, rdycnt[1][1] - snap, 0);
    chk("t6_p1_rvalid", 1, rvcnt[1][1] - snap2, 0);

    // 3: continuous tie after reset alternates starting with p0
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    v[0][0] = 1'b1; we_i[0][0] = 1'b0; ad[0][0] = 32'h100;
    v[0][1] = 1'b1; we_i[0][1] = 1'b0; ad[0][1] = 32'h104;
    order = '{-1, -1, -1, -1};
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (rdy[0][0])      begin order[n] = 0; n++; end
      else if (rdy[0][1]) begin order[n] = 1; n++; end
    end
    @(posedge clk);
    #1 v[0][0] = 1'b0; v[0][1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant_order", 0, order[i], exp_order[i]);
      if (i > 0) chk("t3_no_repeat", 0, 32'(order[i] == order[i-1]), 0);
    end
    repeat (4) @(posedge clk);
    #1;

    // 5: reset in the middle of a write
    v[1][0] = 1'b1; we_i[1][0] = 1'b1; ad[1][0] = 32'h80; wd[1][0] = 32'hCAFEF00D;
    ths = -1;
    for (int i = 0; i < 20 && ths < 0; i++) begin
      @(negedge clk);
      if (rdy[1][0]) ths = cyc;
    end
    chk("t5_handshake_seen", 1, 32'(ths >= 0), 1);
    @(posedge clk);
    #1 v[1][0] = 1'b0;
    chk("t5_write_active", 1, mwrite[1], 1);
    snap = rvcnt[1][0] + rvcnt[1][1];
    #2 reset_n = 1'b0;
    #1;
    chk("t5_write_dropped", 1, mwrite[1], 0);
    chk("t5_read_low",      1, mread[1], 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_rvalid", 1, rvcnt[1][0] + rvcnt[1][1] - snap, 0);
    v[1][0] = 1'b1; we_i[1][0] = 1'b0; ad[1][0] = 32'h8;
    v[1][1] = 1'b1; we_i[1][1] = 1'b0; ad[1][1] = 32'hC;
    first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      @(negedge clk);
      if (rdy[1][0])      first = 0;
      else if (rdy[1][1]) first = 1;
    end
    @(posedge clk);
    #1 v[1][0] = 1'b0; v[1][1] = 1'b0;
    chk("t5_first_tie", 1, first, 0);
    repeat (6) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
